// File: rtl/pd1_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Debug memory access engine: turns OCI memory strobes from the debug
// slave wrapper into single-beat reads/writes on a waitrequest port.
module pd1_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         mon_q, mon_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [ADDR_W-1:0]   a_addr;
  logic                a_rd;
  logic                a_clr;
  logic                unused_jdo;

  assign a_addr     = jdo[17 +: ADDR_W];
  assign a_rd       = jdo[34];
  assign a_clr      = jdo[35];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mon_q   <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mon_q   <= mon_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mon_d   = mon_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // strobes may overlap; write wins, then load, then plain read
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          mon_d   = jdo[34:3];
          rdy_d   = 1'b0;
          wr_d    = 1'b1;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (take_action_ocimem_a) begin
          addr_d = a_addr;
          if (a_clr) err_d = 1'b0;
          if (a_rd) begin
            rdy_d   = 1'b0;
            rd_d    = 1'b1;
            cnt_d   = '0;
            state_d = READ;
          end
        end else if (take_no_action_ocimem_a) begin
          rdy_d   = 1'b0;
          rd_d    = 1'b1;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (!mem_waitrequest) begin
          if (state_q == READ) mon_d = mem_readdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MonDReg       = mon_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign mem_address   = addr_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_writedata = wdata_q;

endmodule
